// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline-stage buffer and its users.
package pipe_pkg;

  // Occupancy-coded control states: the state value doubles as the entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // All-zero word is the MIPS nop (sll $0,$0,0), so a flushed stage is a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Field positions inside the IF/ID instance bus (field 0 in the LSBs).
  localparam int F_INSTR  = 0;
  localparam int F_PCNEXT = 1;

endpackage

// File: rtl/pipe_entry_reg.sv
// One held entry of the stage: FIELDS x WIDTH register with load enable and
// synchronous clear that loads FLUSH_VALUE into every field.
module pipe_entry_reg #(
  parameter int               WIDTH       = 32,
  parameter int               FIELDS      = 2,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic                    Clk,
  input  logic                    Clr,
  input  logic                    Load,
  input  logic [FIELDS*WIDTH-1:0] D,
  output logic [FIELDS*WIDTH-1:0] Q
);

  logic [FIELDS*WIDTH-1:0] flush_word;
  logic [FIELDS*WIDTH-1:0] q_reg;

  // Replicate the per-field clear value across the whole bus.
  generate
    for (genvar gi = 0; gi < FIELDS; gi++) begin : g_flush_field
      assign flush_word[gi*WIDTH +: WIDTH] = FLUSH_VALUE;
    end
  endgenerate

  // Clear wins over load; otherwise hold, so the output never goes X.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      q_reg <= flush_word;
    end else if (Load) begin
      q_reg <= D;
    end
  end

  assign Q = q_reg;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage register with valid/ready handshake, flush-to-bubble
// and an optional skid entry that makes In_Ready a pure register output.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               FIELDS      = 2,
  parameter int               SKID        = 1,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [FIELDS*WIDTH-1:0] In_Data,
  input  logic                    Flush,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic [FIELDS*WIDTH-1:0] Out_Data,
  output logic                    Out_Flushed,
  output logic [1:0]              Occupancy
);

  logic [1:0]              state_reg, state_next;
  logic                    out_valid_reg;
  logic                    out_flushed_reg;
  logic                    in_fire, out_fire;
  logic                    main_load, skid_load, main_sel_skid;
  logic                    entry_clr;
  logic [FIELDS*WIDTH-1:0] main_d, main_q, skid_q;

  assign in_fire   = In_Valid & In_Ready;
  assign out_fire  = out_valid_reg & Out_Ready;
  assign entry_clr = Rst | Flush;
  assign main_d    = main_sel_skid ? skid_q : In_Data;

  // Next-state and entry-load decode; Flush overrides to EMPTY and the entry
  // registers are cleared through entry_clr, so their loads are don't-care.
  always_comb begin
    state_next    = state_reg;
    main_load     = 1'b0;
    skid_load     = 1'b0;
    main_sel_skid = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next = ST_ONE;
          main_load  = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          // Only reachable with a skid entry; without one In_Ready implies out_fire.
          if (SKID != 0) begin
            state_next = ST_FULL;
            skid_load  = 1'b1;
          end
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_next    = ST_ONE;
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    if (Flush) begin
      state_next = ST_EMPTY;
    end
  end

  // Control state and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg       <= ST_EMPTY;
      out_valid_reg   <= 1'b0;
      out_flushed_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      out_valid_reg   <= (state_next != ST_EMPTY);
      out_flushed_reg <= Flush;
    end
  end

  pipe_entry_reg #(
    .WIDTH       (WIDTH),
    .FIELDS      (FIELDS),
    .FLUSH_VALUE (FLUSH_VALUE)
  ) u_main (
    .Clk  (Clk),
    .Clr  (entry_clr),
    .Load (main_load),
    .D    (main_d),
    .Q    (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_reg;

      // In_Ready registered: accept whenever the next state leaves room.
      always_ff @(posedge Clk) begin
        if (Rst) begin
          in_ready_reg <= 1'b1;
        end else begin
          in_ready_reg <= (state_next != ST_FULL);
        end
      end

      pipe_entry_reg #(
        .WIDTH       (WIDTH),
        .FIELDS      (FIELDS),
        .FLUSH_VALUE (FLUSH_VALUE)
      ) u_skid (
        .Clk  (Clk),
        .Clr  (entry_clr),
        .Load (skid_load),
        .D    (In_Data),
        .Q    (skid_q)
      );

      assign In_Ready = in_ready_reg;
    end else begin : g_noskid
      logic unused_skid_load;
      assign unused_skid_load = skid_load;
      assign skid_q           = '0;
      // Single entry: space exists if empty or the held entry leaves this cycle.
      assign In_Ready         = ~out_valid_reg | Out_Ready;
    end
  endgenerate

  assign Out_Valid   = out_valid_reg;
  assign Out_Data    = main_q;
  assign Out_Flushed = out_flushed_reg;
  assign Occupancy   = state_reg;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench: driver pushes expected entries, monitors pop on out_fire.
module tb_pipe_stage_buffer;

  localparam int WA = 32, FA = 2;
  localparam int WB = 16, FB = 3;
  localparam logic [WB-1:0] FLUSH_B = 16'h00F0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default IF/ID shape with skid entry
  logic             rst_a, in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a, out_flushed_a;
  logic [FA*WA-1:0] in_data_a, out_data_a;
  logic [1:0]       occ_a;

  // DUT B: single entry, 3 x 16-bit fields, non-zero flush value
  logic             rst_b, in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b, out_flushed_b;
  logic [FB*WB-1:0] in_data_b, out_data_b;
  logic [1:0]       occ_b;

  pipe_stage_buffer #(.WIDTH(WA), .FIELDS(FA), .SKID(1), .FLUSH_VALUE('0)) dut_a (
    .Clk(clk), .Rst(rst_a), .In_Valid(in_valid_a), .In_Ready(in_ready_a), .In_Data(in_data_a),
    .Flush(flush_a), .Out_Valid(out_valid_a), .Out_Ready(out_ready_a), .Out_Data(out_data_a),
    .Out_Flushed(out_flushed_a), .Occupancy(occ_a));

  pipe_stage_buffer #(.WIDTH(WB), .FIELDS(FB), .SKID(0), .FLUSH_VALUE(FLUSH_B)) dut_b (
    .Clk(clk), .Rst(rst_b), .In_Valid(in_valid_b), .In_Ready(in_ready_b), .In_Data(in_data_b),
    .Flush(flush_b), .Out_Valid(out_valid_b), .Out_Ready(out_ready_b), .Out_Data(out_data_b),
    .Out_Flushed(out_flushed_b), .Occupancy(occ_b));

  int total = 0;
  int bad   = 0;
  logic [FA*WA-1:0] qa[$];
  logic [FB*WB-1:0] qb[$];

  localparam logic [63:0] D1  = {32'h0000_0004, 32'h2008_0001};
  localparam logic [63:0] D2  = {32'h0000_0008, 32'h2009_0002};
  localparam logic [63:0] D3  = {32'h0000_000C, 32'h0109_5020};
  localparam logic [63:0] D4  = {32'h0000_0040, 32'h1111_1111};
  localparam logic [63:0] D5  = {32'h0000_0044, 32'h2222_2222};
  localparam logic [63:0] D6  = {32'h0000_0048, 32'h3333_3333};
  localparam logic [63:0] D7  = {32'h0000_004C, 32'h4444_4444};
  localparam logic [63:0] D8  = {32'h0000_0010, 32'h8C08_0000};
  localparam logic [63:0] D9  = {32'h0000_0050, 32'h5555_5555};
  localparam logic [63:0] D10 = {32'h0000_0054, 32'h6666_6666};
  localparam logic [63:0] D11 = {32'h0000_0058, 32'h7777_7777};
  localparam logic [63:0] D12 = {32'h0000_005C, 32'h8888_8888};
  localparam logic [47:0] E1  = {16'h0003, 16'h0002, 16'h0001};
  localparam logic [47:0] E2  = {16'hC0DE, 16'hBEEF, 16'h1234};
  localparam logic [47:0] E3  = {16'h7777, 16'h8888, 16'h9999};
  localparam logic [47:0] FLUSH_WORD_B = {FLUSH_B, FLUSH_B, FLUSH_B};

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic r, input logic [1:0] o, input logic f);
    check({tag, ".a_valid"},   96'(out_valid_a),   96'(v));
    check({tag, ".a_ready"},   96'(in_ready_a),    96'(r));
    check({tag, ".a_occ"},     96'(occ_a),         96'(o));
    check({tag, ".a_flushed"}, 96'(out_flushed_a), 96'(f));
  endtask

  task automatic chk_b(input string tag, input logic v, input logic r, input logic [1:0] o, input logic f);
    check({tag, ".b_valid"},   96'(out_valid_b),   96'(v));
    check({tag, ".b_ready"},   96'(in_ready_b),    96'(r));
    check({tag, ".b_occ"},     96'(occ_b),         96'(o));
    check({tag, ".b_flushed"}, 96'(out_flushed_b), 96'(f));
  endtask

  task automatic drive_a(input logic v, input logic [63:0] d, input logic ordy, input logic fl, input logic push);
    in_valid_a  = v;
    in_data_a   = d;
    out_ready_a = ordy;
    flush_a     = fl;
    if (push) qa.push_back(d);
  endtask

  task automatic drive_b(input logic v, input logic [47:0] d, input logic ordy, input logic fl, input logic push);
    in_valid_b  = v;
    in_data_b   = d;
    out_ready_b = ordy;
    flush_b     = fl;
    if (push) qb.push_back(d);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: compare every delivered entry against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_a && out_valid_a && out_ready_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_out", 96'(out_data_a), 96'h0);
        if (out_data_a === '0) begin
          bad++;
          $display("FAIL a_unexpected_out: actual=entry required=none");
        end
      end else begin
        logic [63:0] e;
        e = qa.pop_front();
        $display("A out: data=%h expected=%h", out_data_a, e);
        check("a_out_data", 96'(out_data_a), 96'(e));
      end
    end
  end

  // Monitor B: same for the single-entry instance.
  always @(negedge clk) begin
    if (!rst_b && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_out: actual=%h required=none", out_data_b);
      end else begin
        logic [47:0] e;
        e = qb.pop_front();
        $display("B out: data=%h expected=%h", out_data_b, e);
        check("b_out_data", 96'(out_data_b), 96'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    drive_a(1'b1, D1, 1'b0, 1'b0, 1'b0);  // In_Valid ignored during reset
    drive_b(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("reset", 1'b0, 1'b1, 2'd0, 1'b0);
    check("reset.a_data", 96'(out_data_a), 96'h0);
    chk_b("reset", 1'b0, 1'b1, 2'd0, 1'b0);
    check("reset.b_data", 96'(out_data_b), 96'(FLUSH_WORD_B));
    to_next();

    // Streaming with Out_Ready high: one entry per cycle, 1-cycle latency.
    drive_a(1'b1, D1, 1'b1, 1'b0, 1'b1); @(negedge clk); chk_a("s0", 1'b0, 1'b1, 2'd0, 1'b0); to_next();
    drive_a(1'b1, D2, 1'b1, 1'b0, 1'b1); @(negedge clk); chk_a("s1", 1'b1, 1'b1, 2'd1, 1'b0); to_next();
    drive_a(1'b1, D3, 1'b1, 1'b0, 1'b1); @(negedge clk); chk_a("s2", 1'b1, 1'b1, 2'd1, 1'b0); to_next();
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0); @(negedge clk); chk_a("s3", 1'b1, 1'b1, 2'd1, 1'b0); to_next();
    @(negedge clk);
    chk_a("s4", 1'b0, 1'b1, 2'd0, 1'b0);
    check("s4.a_data_hold", 96'(out_data_a), 96'(D3));
    to_next();

    // Stall with skid: two entries held, In_Ready drops, then drains in order.
    drive_a(1'b1, D4, 1'b0, 1'b0, 1'b1); @(negedge clk); chk_a("k0", 1'b0, 1'b1, 2'd0, 1'b0); to_next();
    drive_a(1'b1, D5, 1'b0, 1'b0, 1'b1); @(negedge clk); chk_a("k1", 1'b1, 1'b1, 2'd1, 1'b0); to_next();
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0); @(negedge clk);
    chk_a("k2", 1'b1, 1'b0, 2'd2, 1'b0);
    check("k2.a_data_held", 96'(out_data_a), 96'(D4));
    to_next();
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0); @(negedge clk); chk_a("k3", 1'b1, 1'b0, 2'd2, 1'b0); to_next();
    @(negedge clk); chk_a("k4", 1'b1, 1'b1, 2'd1, 1'b0); to_next();

    // Flush while FULL with an incoming entry: everything dropped.
    drive_a(1'b1, D6, 1'b0, 1'b0, 1'b1); @(negedge clk); chk_a("f0", 1'b0, 1'b1, 2'd0, 1'b0); to_next();
    drive_a(1'b1, D7, 1'b0, 1'b0, 1'b1); to_next();
    drive_a(1'b1, D8, 1'b0, 1'b1, 1'b0); @(negedge clk); chk_a("f2", 1'b1, 1'b0, 2'd2, 1'b0); to_next();
    qa.delete();
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0); @(negedge clk);
    chk_a("f3", 1'b0, 1'b1, 2'd0, 1'b1);
    check("f3.a_data", 96'(out_data_a), 96'h0);
    to_next();
    @(negedge clk); chk_a("f4", 1'b0, 1'b1, 2'd0, 1'b0); to_next();

    // Flush in ONE with simultaneous in_fire and out_fire, then back-to-back flush.
    drive_a(1'b1, D9, 1'b1, 1'b0, 1'b1); to_next();
    drive_a(1'b1, D10, 1'b1, 1'b1, 1'b0); @(negedge clk); chk_a("g1", 1'b1, 1'b1, 2'd1, 1'b0); to_next();
    qa.delete();
    drive_a(1'b0, '0, 1'b1, 1'b1, 1'b0); @(negedge clk); chk_a("g2", 1'b0, 1'b1, 2'd0, 1'b1); to_next();
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0); @(negedge clk); chk_a("g3", 1'b0, 1'b1, 2'd0, 1'b1); to_next();
    @(negedge clk); chk_a("g4", 1'b0, 1'b1, 2'd0, 1'b0); to_next();

    // Reset while FULL and stalled: no flush pulse.
    drive_a(1'b1, D11, 1'b0, 1'b0, 1'b1); to_next();
    drive_a(1'b1, D12, 1'b0, 1'b0, 1'b1); to_next();
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0); rst_a = 1'b1;
    @(negedge clk); chk_a("r0", 1'b1, 1'b0, 2'd2, 1'b0); to_next();
    qa.delete();
    rst_a = 1'b0;
    @(negedge clk);
    chk_a("r1", 1'b0, 1'b1, 2'd0, 1'b0);
    check("r1.a_data", 96'(out_data_a), 96'h0);
    to_next();
    check("a_queue_empty", 96'(qa.size()), 96'h0);

    // DUT B: combinational In_Ready and bubble-free replace.
    drive_b(1'b1, E1, 1'b0, 1'b0, 1'b1); @(negedge clk); chk_b("b0", 1'b0, 1'b1, 2'd0, 1'b0); to_next();
    drive_b(1'b1, E2, 1'b0, 1'b0, 1'b0); @(negedge clk);
    chk_b("b1", 1'b1, 1'b0, 2'd1, 1'b0);
    check("b1.b_data", 96'(out_data_b), 96'(E1));
    to_next();
    drive_b(1'b1, E2, 1'b1, 1'b0, 1'b1); @(negedge clk); chk_b("b2", 1'b1, 1'b1, 2'd1, 1'b0); to_next();
    drive_b(1'b0, '0, 1'b1, 1'b0, 1'b0); @(negedge clk); chk_b("b3", 1'b1, 1'b1, 2'd1, 1'b0); to_next();
    @(negedge clk);
    chk_b("b4", 1'b0, 1'b1, 2'd0, 1'b0);
    check("b4.b_data_hold", 96'(out_data_b), 96'(E2));
    to_next();
    drive_b(1'b1, E3, 1'b0, 1'b0, 1'b1); to_next();
    drive_b(1'b0, '0, 1'b0, 1'b1, 1'b0); @(negedge clk); chk_b("b6", 1'b1, 1'b0, 2'd1, 1'b0); to_next();
    qb.delete();
    drive_b(1'b0, '0, 1'b0, 1'b0, 1'b0); @(negedge clk);
    chk_b("b7", 1'b0, 1'b1, 2'd0, 1'b1);
    check("b7.b_data", 96'(out_data_b), 96'(FLUSH_WORD_B));
    to_next();
    check("b_queue_empty", 96'(qb.size()), 96'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
